matrix_fetch_sequencer: RTL and testbench

- Consumes the decoded weight or bias descriptor (height, width, start address) for one layer operand.
- Walks the operand row-major and issues one read per element to the single-port parameter BRAM.
- Streams the returned words downstream with row/col tags and a last flag, under valid/ready backpressure.
- Sits directly downstream of the layer-info decoding stage. One instance is used per operand (weight, bias).

---
 rtl/matrix_fetch_sequencer_if.sv | 72 +++++++
 rtl/matrix_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_matrix_fetch_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_fetch_sequencer_if
// Description : Bundle of the descriptor, parameter-BRAM and output-stream
//               signals of the matrix fetch sequencer. The slave modport is
//               the sequencer's view; the master modport is the view of the
//               surrounding logic (decoder, BRAM and downstream consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    // Operand descriptor from the layer-info decoder
    logic                  start_in;
    logic [3:0]            height_in;
    logic [3:0]            width_in;
    logic [7:0]            start_addr_in;

    // Single-port parameter BRAM read side
    logic                  rd_en_out;
    logic [7:0]            rd_addr_out;
    logic [DATA_WIDTH-1:0] rd_data_in;

    // Tagged element stream
    logic                  out_valid_out;
    logic                  out_ready_in;
    logic [DATA_WIDTH-1:0] out_data_out;
    logic [3:0]            out_row_out;
    logic [3:0]            out_col_out;
    logic                  out_last_out;

    // Status
    logic                  busy_out;
    logic                  done_out;

    modport slave (
        input  start_in,
        input  height_in,
        input  width_in,
        input  start_addr_in,
        output rd_en_out,
        output rd_addr_out,
        input  rd_data_in,
        output out_valid_out,
        input  out_ready_in,
        output out_data_out,
        output out_row_out,
        output out_col_out,
        output out_last_out,
        output busy_out,
        output done_out
    );

    modport master (
        output start_in,
        output height_in,
        output width_in,
        output start_addr_in,
        input  rd_en_out,
        input  rd_addr_out,
        output rd_data_in,
        input  out_valid_out,
        output out_ready_in,
        input  out_data_out,
        input  out_row_out,
        input  out_col_out,
        input  out_last_out,
        input  busy_out,
        input  done_out
    );
endinterface
`default_nettype wire

// File: rtl/matrix_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_fetch_sequencer
// Description : Walks a height x width operand row-major, issues one BRAM read
//               per element under a credit limit, and streams the returned
//               words with row/col/last tags through a small skid FIFO under
//               valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_fetch_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    matrix_fetch_sequencer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold fifo_count + inflight_count without overflow
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    // FIFO entry layout: {last, row[3:0], col[3:0], data}
    localparam int c_tag_w   = 9;
    localparam int c_entry_w = DATA_WIDTH + c_tag_w;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
            $error("matrix_fetch_sequencer: FIFO_DEPTH must be >= READ_LATENCY+1");
        end
        if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_latency_check
            $error("matrix_fetch_sequencer: READ_LATENCY must be in 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------------
    // Descriptor and walk registers
    // ------------------------------------------------------------------------
    logic [3:0] r_height;
    logic [3:0] r_width;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic [7:0] r_addr;
    logic       r_zero_done;

    // ------------------------------------------------------------------------
    // In-flight tracker: one slot per BRAM pipeline stage
    // ------------------------------------------------------------------------
    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic [c_tag_w-1:0]      r_pipe_tag [READ_LATENCY];

    // ------------------------------------------------------------------------
    // Output skid FIFO
    // ------------------------------------------------------------------------
    logic [c_entry_w-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_fifo_count;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0]   w_inflight;
    logic                 w_credit_ok;
    logic                 w_zero;
    logic                 w_at_end;
    logic                 w_capture;
    logic                 w_issue;
    logic                 w_done_drain;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_valid;
    logic [c_entry_w-1:0] w_head;
    logic                 w_head_last;

    // Circular pointer advance that also works for non-power-of-two depths
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        if (p == c_ptr_w'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + c_ptr_w'(1);
    endfunction

    assign w_zero       = (bus.height_in == 4'd0) || (bus.width_in == 4'd0);
    assign w_at_end     = (r_row == (r_height - 4'd1)) && (r_col == (r_width - 4'd1));
    assign w_fifo_valid = (r_fifo_count != '0);
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_head_last  = w_head[c_entry_w-1];
    assign w_pop        = w_fifo_valid && bus.out_ready_in;
    assign w_push       = r_pipe_valid[READ_LATENCY-1];

    // Count reads still travelling through the BRAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_cnt_w'(r_pipe_valid[i]);
        end
    end

    // Every issued read already owns a FIFO slot, so the FIFO cannot overflow
    assign w_credit_ok = ((r_fifo_count + w_inflight) < c_cnt_w'(FIFO_DEPTH));

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_issue      = 1'b0;
        w_done_drain = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_in) begin
                    w_capture = 1'b1;
                    if (!w_zero) begin
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_at_end) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The last element can only reach the FIFO head after the
                // final read was issued, so it is always accepted here.
                if (w_pop && w_head_last) begin
                    w_done_drain = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Descriptor capture and row-major walk; the address runs linearly
    // because row*width+col advances by one per element
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_height    <= 4'd0;
            r_width     <= 4'd0;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_addr      <= 8'd0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_capture && w_zero;
            if (w_capture) begin
                r_height <= bus.height_in;
                r_width  <= bus.width_in;
                r_addr   <= bus.start_addr_in;
                r_row    <= 4'd0;
                r_col    <= 4'd0;
            end else if (w_issue) begin
                r_addr <= r_addr + 8'd1;
                if (r_col == (r_width - 4'd1)) begin
                    r_col <= 4'd0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= r_col + 4'd1;
                end
            end
        end
    end

    // Tag shift register tracking each read through the BRAM latency;
    // clearing it on reset discards data for reads issued before reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= w_issue;
            r_pipe_tag[0]   <= {w_at_end, r_row, r_col};
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_tag[i]   <= r_pipe_tag[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count as is
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_cnt_w'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_cnt_w'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid-gated outputs
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_pipe_tag[READ_LATENCY-1], bus.rd_data_in};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: gated so that everything reads zero while idle/empty
    // ------------------------------------------------------------------------
    assign bus.rd_en_out     = w_issue;
    assign bus.rd_addr_out   = w_issue ? r_addr : 8'h00;
    assign bus.out_valid_out = w_fifo_valid;
    assign bus.out_data_out  = w_fifo_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign bus.out_col_out   = w_fifo_valid ? w_head[DATA_WIDTH+3:DATA_WIDTH] : 4'd0;
    assign bus.out_row_out   = w_fifo_valid ? w_head[DATA_WIDTH+7:DATA_WIDTH+4] : 4'd0;
    assign bus.out_last_out  = w_fifo_valid && w_head_last;
    assign bus.busy_out      = (r_state != S_IDLE);
    assign bus.done_out      = r_zero_done || w_done_drain;

endmodule
`default_nettype wire

// File: tb/tb_matrix_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_fetch_sequencer
// Description : Self-checking bench for matrix_fetch_sequencer. A behavioural
//               BRAM answers reads; a transaction-level model predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_fetch_sequencer;

    localparam int DW = 16;
    localparam int RL = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    matrix_fetch_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    matrix_fetch_sequencer #(
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    // ------------------------------------------------------------------------
    // Behavioural parameter BRAM with RL-cycle read latency
    // ------------------------------------------------------------------------
    logic [DW-1:0] mem [256];
    logic [7:0]    ba  [RL];

    initial begin
        for (int i = 0; i < RL; i++) ba[i] = 8'h00;
    end

    // Address pipeline: data for a read in cycle t is presented in cycle t+RL
    always @(posedge clk) begin
        ba[0] <= bus.rd_addr_out;
        for (int i = 1; i < RL; i++) ba[i] <= ba[i-1];
    end
    assign bus.rd_data_in = mem[ba[RL-1]];

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model: a fetch is the list of elements k=0..h*w-1 at
    // address base+k; a read may be outstanding only while fewer than FD
    // elements are issued-but-not-accepted; an element is presentable RL+1
    // cycles after its read.
    // ------------------------------------------------------------------------
    bit         chk_en = 1'b0;
    bit         m_active = 1'b0;
    bit         zero_pend = 1'b0;
    int         m_total = 0;
    int         m_w = 1;
    int         m_base = 0;
    int         n_iss = 0;
    int         n_acc = 0;
    int         iss_t [256];

    // Observed-activity monitors used by the directed checks
    int         n_rd = 0;
    int         n_out = 0;
    int         n_done = 0;
    int         n_lastflag = 0;
    int         done_cyc = 0;
    int         first_valid_cyc = -1;
    logic [7:0] rd_log [1024];

    function automatic logic [7:0] exp_addr(input int k);
        return 8'(m_base + k);
    endfunction

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        bit e_rd;
        bit e_val;
        bit acc;
        bit e_done;
        bit was_active;
        if (chk_en) begin
            e_rd  = m_active && (n_iss < m_total) && ((n_iss - n_acc) < FD);
            e_val = m_active && (n_acc < n_iss) && (iss_t[n_acc] + RL + 1 <= cyc);
            acc   = e_val && bus.out_ready_in;
            e_done = zero_pend || (acc && (n_acc == m_total - 1));

            chk("rd_en", 64'(bus.rd_en_out), 64'(e_rd));
            if (e_rd) chk("rd_addr", 64'(bus.rd_addr_out), 64'(exp_addr(n_iss)));
            chk("out_valid", 64'(bus.out_valid_out), 64'(e_val));
            if (e_val) begin
                chk("out_data", 64'(bus.out_data_out), 64'(mem[exp_addr(n_acc)]));
                chk("out_row", 64'(bus.out_row_out), 64'(n_acc / m_w));
                chk("out_col", 64'(bus.out_col_out), 64'(n_acc % m_w));
                chk("out_last", 64'(bus.out_last_out), 64'(n_acc == m_total - 1));
            end
            chk("done", 64'(bus.done_out), 64'(e_done));
            chk("busy", 64'(bus.busy_out), 64'(m_active));

            if (bus.rd_en_out) begin
                rd_log[n_rd % 1024] = bus.rd_addr_out;
                n_rd++;
            end
            if (bus.out_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid_out && bus.out_ready_in) begin
                n_out++;
                if (bus.out_last_out) n_lastflag++;
            end
            if (bus.done_out) begin
                n_done++;
                done_cyc = cyc;
            end

            was_active = m_active;
            zero_pend  = 1'b0;
            if (e_rd) begin
                iss_t[n_iss] = cyc;
                n_iss++;
            end
            if (acc) begin
                n_acc++;
                if (n_acc == m_total) m_active = 1'b0;
            end
            if (bus.start_in && !was_active) begin
                if (bus.height_in == 4'd0 || bus.width_in == 4'd0) begin
                    zero_pend = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_total  = int'(bus.height_in) * int'(bus.width_in);
                    m_w      = int'(bus.width_in);
                    m_base   = int'(bus.start_addr_in);
                    n_iss    = 0;
                    n_acc    = 0;
                end
            end
        end
        if (!rst_n) begin
            chk_en    = 1'b1;
            m_active  = 1'b0;
            zero_pend = 1'b0;
            n_iss     = 0;
            n_acc     = 0;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------------
    task automatic start_fetch(input logic [3:0] h, input logic [3:0] w,
                               input logic [7:0] a, output int t0);
        first_valid_cyc   = -1;
        bus.start_in      = 1'b1;
        bus.height_in     = h;
        bus.width_in      = w;
        bus.start_addr_in = a;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        int i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < budget) begin
            @(posedge clk);
            #1;
            if (rnd) bus.out_ready_in = 1'($urandom_range(0, 1));
            i++;
        end
        bus.out_ready_in = 1'b1;
        chk("done_within_budget", 64'(n_done != d0), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog against a hung run
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int t0, r0, o0, d0, l0, i;

        for (int a = 0; a < 256; a++) mem[a] = {8'(a) ^ 8'hA5, 8'(a)};
        bus.start_in      = 1'b0;
        bus.height_in     = 4'd0;
        bus.width_in      = 4'd0;
        bus.start_addr_in = 8'd0;
        bus.out_ready_in  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy_out), 64'd0);
        chk("reset_valid", 64'(bus.out_valid_out), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 2x3 at 0x10, ready high: reads on 6 consecutive cycles from start+1
        r0 = n_rd; o0 = n_out; l0 = n_lastflag;
        start_fetch(4'd2, 4'd3, 8'h10, t0);
        wait_done(40, 1'b0);
        idle(2);
        chk("t1_reads", 64'(n_rd - r0), 64'd6);
        chk("t1_addr_first", 64'(rd_log[r0]), 64'h10);
        chk("t1_addr_last", 64'(rd_log[r0 + 5]), 64'h15);
        chk("t1_elems", 64'(n_out - o0), 64'd6);
        chk("t1_last_count", 64'(n_lastflag - l0), 64'd1);
        // first element: read in cycle t0, RL cycles in BRAM, one into FIFO
        chk("t1_first_valid_rel", 64'(first_valid_cyc - t0), 64'd3);
        // last read at t0+5, accepted at t0+5+RL+1
        chk("t1_done_rel", 64'(done_cyc - t0), 64'd8);

        // 1x4 at 0xFE: address wraps past 0xFF
        r0 = n_rd;
        start_fetch(4'd1, 4'd4, 8'hFE, t0);
        wait_done(40, 1'b0);
        idle(2);
        chk("t2_addr0", 64'(rd_log[r0]), 64'hFE);
        chk("t2_addr1", 64'(rd_log[r0 + 1]), 64'hFF);
        chk("t2_addr2", 64'(rd_log[r0 + 2]), 64'h00);
        chk("t2_addr3", 64'(rd_log[r0 + 3]), 64'h01);

        // 3x3 with ready dropped after the first element
        r0 = n_rd; o0 = n_out;
        start_fetch(4'd3, 4'd3, 8'h80, t0);
        i = 0;
        while (n_out == o0 && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        bus.out_ready_in = 1'b0;
        idle(12);
        // one accepted plus FD outstanding credits
        chk("t3_reads_stalled", 64'(n_rd - r0), 64'd5);
        chk("t3_elems_stalled", 64'(n_out - o0), 64'd1);
        chk("t3_hold_col", 64'(bus.out_col_out), 64'd1);
        chk("t3_hold_data", 64'(bus.out_data_out), 64'h2481);
        bus.out_ready_in = 1'b1;
        wait_done(60, 1'b0);
        idle(2);
        chk("t3_elems", 64'(n_out - o0), 64'd9);
        chk("t3_reads", 64'(n_rd - r0), 64'd9);

        // zero width: no reads, done one cycle after start
        r0 = n_rd; o0 = n_out; d0 = n_done;
        start_fetch(4'd3, 4'd0, 8'h20, t0);
        idle(4);
        chk("t4_zero_reads", 64'(n_rd - r0), 64'd0);
        chk("t4_zero_elems", 64'(n_out - o0), 64'd0);
        chk("t4_zero_done", 64'(n_done - d0), 64'd1);
        chk("t4_zero_done_rel", 64'(done_cyc - t0), 64'd0);

        // start while busy is ignored
        r0 = n_rd; o0 = n_out;
        start_fetch(4'd2, 4'd3, 8'h00, t0);
        idle(2);
        bus.start_in      = 1'b1;
        bus.height_in     = 4'd5;
        bus.width_in      = 4'd5;
        bus.start_addr_in = 8'h90;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        wait_done(40, 1'b0);
        idle(3);
        chk("t4_busy_start_elems", 64'(n_out - o0), 64'd6);
        chk("t4_busy_start_reads", 64'(n_rd - r0), 64'd6);

        // reset in the middle of a 4x4 with reads in flight
        start_fetch(4'd4, 4'd4, 8'h30, t0);
        idle(3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_reset_outputs",
            {27'd0, bus.rd_en_out, bus.rd_addr_out, bus.out_valid_out, bus.out_data_out,
             bus.out_row_out, bus.out_col_out, bus.out_last_out, bus.busy_out, bus.done_out},
            64'd0);
        rst_n = 1'b1;
        o0 = n_out; l0 = n_lastflag;
        idle(6);
        chk("t5_no_stale", 64'(n_out - o0), 64'd0);
        start_fetch(4'd1, 4'd1, 8'h33, t0);
        wait_done(20, 1'b0);
        idle(2);
        chk("t5_one_elem", 64'(n_out - o0), 64'd1);
        chk("t5_one_last", 64'(n_lastflag - l0), 64'd1);

        // 8x8 at 0x40 with random backpressure
        r0 = n_rd; o0 = n_out; d0 = n_done; l0 = n_lastflag;
        start_fetch(4'd8, 4'd8, 8'h40, t0);
        wait_done(600, 1'b1);
        idle(4);
        chk("t6_elems", 64'(n_out - o0), 64'd64);
        chk("t6_reads", 64'(n_rd - r0), 64'd64);
        chk("t6_done_once", 64'(n_done - d0), 64'd1);
        chk("t6_last_once", 64'(n_lastflag - l0), 64'd1);
        chk("t6_addr_first", 64'(rd_log[r0]), 64'h40);
        chk("t6_addr_last", 64'(rd_log[r0 + 63]), 64'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
